// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2**ADDR x WIDTH register file, two registered read ports with write-through bypass
module reg_file #(
   parameter int WIDTH = 32,
   parameter int ADDR  = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [ADDR-1:0]  Adr1,
   input  logic [ADDR-1:0]  Adr2,
   input  logic [ADDR-1:0]  Awr,
   input  logic [WIDTH-1:0] Din,
   input  logic             WE,
   output logic [WIDTH-1:0] Dout1,
   output logic [WIDTH-1:0] Dout2
);

   localparam int DEPTH = 2 ** ADDR;

   logic [WIDTH-1:0] regs [DEPTH];
   logic             wr_ok;
   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd2;

   assign wr_ok = WE && (Awr != '0);

   // Address 0 is hardwired to zero; otherwise a same-edge write wins over stored contents.
   always_comb begin
      rd1 = regs[Adr1];
      rd2 = regs[Adr2];
      if (Adr1 == '0)
         rd1 = '0;
      else if (wr_ok && (Adr1 == Awr))
         rd1 = Din;
      if (Adr2 == '0)
         rd2 = '0;
      else if (wr_ok && (Adr2 == Awr))
         rd2 = Din;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         Dout1 <= '0;
         Dout2 <= '0;
      end else begin
         regs[0] <= '0;
         for (int i = 1; i < DEPTH; i++)
            if (wr_ok && (Awr == ADDR'(i)))
               regs[i] <= Din;
         Dout1 <= rd1;
         Dout2 <= rd2;
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file against an array reference model
module tb_reg_file;

   logic        CLK = 1'b0;
   logic        RST;
   logic [4:0]  Adr1, Adr2, Awr;
   logic [31:0] Din;
   logic        WE;
   logic [31:0] Dout1, Dout2;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [32];
   logic [31:0] q1 [$];
   logic [31:0] q2 [$];
   string       qn [$];

   reg_file #(.WIDTH(32), .ADDR(5)) dut (
      .CLK(CLK), .RST(RST), .Adr1(Adr1), .Adr2(Adr2), .Awr(Awr),
      .Din(Din), .WE(WE), .Dout1(Dout1), .Dout2(Dout2)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference read: what a port shows after the edge at which these inputs are sampled
   function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                            input logic [4:0] aw, input logic [31:0] d);
      if (a == 0) return 32'h0;
      if (we && aw == a) return d;
      return mem[a];
   endfunction

   task automatic model_reset();
      foreach (mem[i]) mem[i] = 32'h0;
   endtask

   task automatic step(input string name, input logic we, input logic [4:0] aw,
                       input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
      @(negedge CLK);
      WE = we; Awr = aw; Din = d; Adr1 = a1; Adr2 = a2;
      q1.push_back(ref_read(a1, we, aw, d));
      q2.push_back(ref_read(a2, we, aw, d));
      qn.push_back(name);
      if (we && aw != 0) mem[aw] = d;
   endtask

   // Monitor: outputs are registered, so every sampling edge yields one result
   always @(posedge CLK) begin
      #1;
      if (q1.size() > 0) begin
         string n;
         n = qn.pop_front();
         chk({n, "_dout1"}, Dout1, q1.pop_front());
         chk({n, "_dout2"}, Dout2, q2.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0] aw, a1, a2;
      logic       we;
      RST = 1'b1; WE = 1'b0; Awr = 0; Din = 0; Adr1 = 0; Adr2 = 0;
      model_reset();
      #1;
      chk("por_dout1", Dout1, 32'h0);
      chk("por_dout2", Dout2, 32'h0);
      @(negedge CLK);
      RST = 1'b0;

      // Some content so that the reset pulse has something to clear
      for (int i = 1; i < 32; i++)
         step("prefill", 1'b1, 5'(i), $urandom, 5'(i - 1), 5'(i));
      @(posedge CLK);
      #2 RST = 1'b1;
      #1 chk("pulse_dout1", Dout1, 32'h0);
      chk("pulse_dout2", Dout2, 32'h0);
      #1 RST = 1'b0;
      model_reset();
      for (int i = 0; i < 32; i++)
         step("reset_read", 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

      step("wr7", 1'b1, 5'd7, 32'hA5A5_0001, 5'd0, 5'd0);
      step("rd7", 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
      step("nowr7", 1'b0, 5'd7, 32'hFFFF_FFFF, 5'd7, 5'd0);
      step("rd7b", 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

      step("r0wr", 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
      step("r0rd", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

      step("wr3", 1'b1, 5'd3, 32'h11, 5'd0, 5'd0);
      step("wr4", 1'b1, 5'd4, 32'h44, 5'd3, 5'd0);
      step("bypass", 1'b1, 5'd3, 32'h22, 5'd3, 5'd4);
      step("after_bypass", 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);

      // Mid-stream async reset drops outputs before the next edge
      step("wr9", 1'b1, 5'd9, 32'h55, 5'd0, 5'd0);
      step("rd9", 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
      @(posedge CLK);
      #2 RST = 1'b1;
      #1 chk("async_dout1", Dout1, 32'h0);
      chk("async_dout2", Dout2, 32'h0);
      #1 RST = 1'b0;
      #0.5 chk("released_dout1", Dout1, 32'h0);
      model_reset();
      step("rd9_post", 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);

      // A write coincident with an edge while reset is held must be blocked
      @(posedge CLK);
      #1;
      @(negedge CLK);
      RST = 1'b1; WE = 1'b1; Awr = 5'd5; Din = 32'h77; Adr1 = 5'd5; Adr2 = 5'd5;
      @(posedge CLK);
      #1 chk("held_rst_dout1", Dout1, 32'h0);
      chk("held_rst_dout2", Dout2, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      WE = 1'b0;
      step("rd5_post", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

      for (int i = 1; i < 32; i++)
         step("fill", 1'b1, 5'(i), 32'(100 + i), 5'd0, 5'd0);
      for (int i = 1; i < 32; i++)
         step("sweep", 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

      for (int n = 0; n < 400; n++) begin
         we = ($urandom_range(0, 3) != 0);
         aw = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 3) == 0) ? aw : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? aw : (($urandom_range(0, 4) == 0) ? a1 : 5'($urandom_range(0, 31)));
         step("random", we, aw, $urandom, a1, a2);
      end
      for (int i = 0; i < 32; i++)
         step("final_dump", 1'b0, 5'd0, 32'hFFFF_FFFF, 5'(i), 5'(31 - i));

      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (q1.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected=0", q1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
